// File: rtl/bus_device_endpoint_pkg.sv
// Shared definitions for the bus device endpoint: packet field layout,
// broadcast default and statistics counter helpers.
package bus_device_endpoint_pkg;

  // Destination ID field, counted down from the packet MSB:
  // the field spans [BITS-ID_HI : BITS-ID_LO].
  localparam int unsigned ID_HI = 1;
  localparam int unsigned ID_LO = 8;
  localparam int unsigned ID_W  = ID_LO - ID_HI + 1;

  // Destination ID accepted by every endpoint unless overridden.
  localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

  // Statistics counters.
  localparam int unsigned CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  // Increment when enabled, holding at the maximum instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + cnt_t'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// First-word fall-through FIFO. A write into a full FIFO is accepted when a
// read happens in the same cycle; reads of an empty FIFO are ignored.
module bus_fifo #(
  parameter int BITS        = 32,
  parameter int profundidad = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [BITS-1:0] wr_data,
  input  logic            rd,
  output logic [BITS-1:0] rd_data,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(profundidad);

  logic [BITS-1:0] mem [profundidad];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  // One extra bit so a full FIFO is distinguishable from an empty one.
  logic [AW:0]     count;
  logic            do_wr;
  logic            do_rd;

  // Effective read/write qualification and status flags.
  always_comb begin
    empty = (count == '0);
    full  = (count == (AW+1)'(profundidad));
    do_rd = rd && !empty;
    do_wr = wr && (!full || do_rd);
  end

  // Pointer and occupancy update; pointers wrap naturally at the depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since the output is gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Head of queue, forced to zero when empty so reset clears the output.
  always_comb begin
    rd_data = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/bus_device_endpoint.sv
// Bus endpoint: a host-to-bus TX FIFO, a bus-to-host RX FIFO with destination
// filtering, and saturating traffic statistics.
module bus_device_endpoint
  import bus_device_endpoint_pkg::*;
#(
  parameter int              BITS        = 32,
  parameter int              profundidad = 8,
  parameter logic [ID_W-1:0] ID          = '0,
  parameter logic [ID_W-1:0] broadcast   = BCAST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  // Bus side
  output logic             pndng,
  output logic [BITS-1:0]  D_pop,
  input  logic             pop,
  input  logic             push,
  input  logic [BITS-1:0]  D_push,
  // Host side
  input  logic             host_wr,
  input  logic [BITS-1:0]  host_wr_data,
  output logic             host_full,
  input  logic             host_rd,
  output logic [BITS-1:0]  host_rd_data,
  output logic             host_rx_valid,
  // Statistics
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] misroute_count
);

  logic            tx_empty;
  logic            tx_full;
  logic            rx_empty;
  logic            rx_full;
  logic [ID_W-1:0] dest;
  logic            rx_match;
  logic            tx_pop_ev;
  logic            rx_rd_ev;
  logic            rx_store_ev;
  logic            rx_drop_ev;
  logic            misroute_ev;

  bus_fifo #(
    .BITS        (BITS),
    .profundidad (profundidad)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (host_wr),
    .wr_data (host_wr_data),
    .rd      (pop),
    .rd_data (D_pop),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  // Only packets addressed to this endpoint (or broadcast) reach the RX FIFO.
  bus_fifo #(
    .BITS        (BITS),
    .profundidad (profundidad)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (push && rx_match),
    .wr_data (D_push),
    .rd      (host_rd),
    .rd_data (host_rd_data),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  // Status flags and per-cycle events feeding the statistics counters.
  always_comb begin
    pndng         = !tx_empty;
    host_full     = tx_full;
    host_rx_valid = !rx_empty;
    dest          = D_push[BITS-ID_HI -: ID_W];
    rx_match      = (dest == ID) || (dest == broadcast);
    tx_pop_ev     = pop && !tx_empty;
    rx_rd_ev      = host_rd && !rx_empty;
    // Mirrors the FIFO's own acceptance rule so counts match what is stored.
    rx_store_ev   = push && rx_match && (!rx_full || rx_rd_ev);
    rx_drop_ev    = push && rx_match && rx_full && !rx_rd_ev;
    misroute_ev   = push && !rx_match;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count       <= '0;
      rx_count       <= '0;
      drop_count     <= '0;
      misroute_count <= '0;
    end else begin
      tx_count       <= sat_inc(tx_count, tx_pop_ev);
      rx_count       <= sat_inc(rx_count, rx_store_ev);
      drop_count     <= sat_inc(drop_count, rx_drop_ev);
      misroute_count <= sat_inc(misroute_count, misroute_ev);
    end
  end

endmodule

// File: tb/tb_bus_device_endpoint.sv
// Scoreboard bench for bus_device_endpoint: a queue-based reference model
// updated at each clock edge, a negedge monitor comparing DUT outputs against
// it, directed scenarios and a randomized phase.
module tb_bus_device_endpoint;

  localparam int          BITS  = 32;
  localparam int          DEPTH = 8;
  localparam logic [7:0]  MY_ID = 8'h02;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic        host_wr = 1'b0;
  logic        host_rd = 1'b0;
  logic [31:0] D_push = '0;
  logic [31:0] host_wr_data = '0;
  logic        pndng;
  logic        host_full;
  logic        host_rx_valid;
  logic [31:0] D_pop;
  logic [31:0] host_rd_data;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [15:0] drop_count;
  logic [15:0] misroute_count;

  always #5 clk = ~clk;

  bus_device_endpoint #(
    .BITS        (BITS),
    .profundidad (DEPTH),
    .ID          (MY_ID),
    .broadcast   (8'hFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pndng          (pndng),
    .D_pop          (D_pop),
    .pop            (pop),
    .push           (push),
    .D_push         (D_push),
    .host_wr        (host_wr),
    .host_wr_data   (host_wr_data),
    .host_full      (host_full),
    .host_rd        (host_rd),
    .host_rd_data   (host_rd_data),
    .host_rx_valid  (host_rx_valid),
    .tx_count       (tx_count),
    .rx_count       (rx_count),
    .drop_count     (drop_count),
    .misroute_count (misroute_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: packet queues and unbounded event counts.
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int          m_tx = 0;
  int          m_rx = 0;
  int          m_drop = 0;
  int          m_mis = 0;

  function automatic logic [15:0] sat(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs presented at each rising edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_tx = 0;
      m_rx = 0;
      m_drop = 0;
      m_mis = 0;
    end else begin
      logic tp, tw, rr, hit;
      tp  = pop && (tx_q.size() > 0);
      tw  = host_wr && ((tx_q.size() < DEPTH) || tp);
      rr  = host_rd && (rx_q.size() > 0);
      hit = (D_push[31:24] == MY_ID) || (D_push[31:24] == 8'hFF);
      if (tp) begin
        void'(tx_q.pop_front());
        m_tx++;
      end
      if (tw) tx_q.push_back(host_wr_data);
      if (rr) void'(rx_q.pop_front());
      if (push) begin
        if (!hit) m_mis++;
        else if ((rx_q.size() + (rr ? 1 : 0) < DEPTH) || rr) begin
          rx_q.push_back(D_push);
          m_rx++;
        end else m_drop++;
      end
    end
  end

  // Monitor: compare every observable output against the model mid-cycle.
  always @(negedge clk) begin
    chk("pndng", 32'(pndng), 32'(tx_q.size() != 0));
    chk("host_full", 32'(host_full), 32'(tx_q.size() == DEPTH));
    chk("host_rx_valid", 32'(host_rx_valid), 32'(rx_q.size() != 0));
    chk("tx_count", 32'(tx_count), 32'(sat(m_tx)));
    chk("rx_count", 32'(rx_count), 32'(sat(m_rx)));
    chk("drop_count", 32'(drop_count), 32'(sat(m_drop)));
    chk("misroute_count", 32'(misroute_count), 32'(sat(m_mis)));
    if (tx_q.size() > 0) chk("D_pop_head", D_pop, tx_q[0]);
    if (rx_q.size() > 0) chk("host_rd_data_head", host_rd_data, rx_q[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] wd, input logic p,
                       input logic ps, input logic [31:0] pd, input logic r);
    host_wr      = w;
    host_wr_data = wd;
    pop          = p;
    push         = ps;
    D_push       = pd;
    host_rd      = r;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pndng"}, 32'(pndng), 32'd0);
    chk({tag, "_host_full"}, 32'(host_full), 32'd0);
    chk({tag, "_host_rx_valid"}, 32'(host_rx_valid), 32'd0);
    chk({tag, "_D_pop"}, D_pop, 32'd0);
    chk({tag, "_host_rd_data"}, host_rd_data, 32'd0);
    chk({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    chk({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    chk({tag, "_misroute_count"}, 32'(misroute_count), 32'd0);
  endtask

  initial begin
    logic [7:0] dst;
    // Reset state, then release between clock edges.
    #2;
    chk_cleared("reset");
    #10;
    reset = 1'b0;
    step();

    // Two host writes, two bus pops.
    drive(1'b1, 32'h02000011, 1'b0, 1'b0, '0, 1'b0);
    step();
    drive(1'b1, 32'h05000022, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("tx_first_head", D_pop, 32'h02000011);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step();
    chk("tx_second_head", D_pop, 32'h05000022);
    step();
    idle();
    chk("tx_drained_pndng", 32'(pndng), 32'd0);
    chk("tx_count_two", 32'(tx_count), 32'd2);

    // Fill TX, write+pop when full, rejected write, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h01000000 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
      step();
    end
    idle();
    chk("tx_full_after_8", 32'(host_full), 32'd1);
    drive(1'b1, 32'h000000AA, 1'b1, 1'b0, '0, 1'b0);
    step();
    chk("tx_full_after_wr_pop", 32'(host_full), 32'd1);
    chk("tx_head_after_wr_pop", D_pop, 32'h01000001);
    drive(1'b1, 32'h000000BB, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("tx_head_after_rejected", D_pop, 32'h01000001);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      if (k == DEPTH - 1) chk("tx_last_is_wr_pop_data", D_pop, 32'h000000AA);
      step();
    end
    step();  // pop on empty, must be ignored
    idle();
    chk("tx_empty_after_drain", 32'(pndng), 32'd0);

    // RX filtering: own ID, broadcast, foreign ID.
    drive(1'b0, '0, 1'b0, 1'b1, 32'h02000A0A, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b1, 32'hFF000B0B, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b1, 32'h03000C0C, 1'b0);
    step();
    idle();
    chk("rx_count_two", 32'(rx_count), 32'd2);
    chk("misroute_one", 32'(misroute_count), 32'd1);
    chk("rx_first_head", host_rd_data, 32'h02000A0A);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step();
    chk("rx_second_head", host_rd_data, 32'hFF000B0B);
    step();
    step();  // read on empty, must be ignored
    idle();
    chk("rx_empty_after_reads", 32'(host_rx_valid), 32'd0);

    // RX overflow and drop counter saturation.
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 32'h02000100 + 32'(i), 1'b0);
      step();
    end
    idle();
    chk("drop_one", 32'(drop_count), 32'd1);
    chk("rx_count_ten", 32'(rx_count), 32'd10);
    drive(1'b0, '0, 1'b0, 1'b1, 32'hFF00DEAD, 1'b0);
    for (int i = 0; i < 65534; i++) step();
    chk("drop_at_max", 32'(drop_count), 32'h0000FFFF);
    step();
    idle();
    chk("drop_saturated", 32'(drop_count), 32'h0000FFFF);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step();
    idle();

    // Asynchronous reset with both FIFOs half full.
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(1'b1, 32'h07000000 + 32'(i), 1'b0, 1'b1, 32'h02000200 + 32'(i), 1'b0);
      step();
    end
    idle();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_cleared("async_reset");
    #10;
    reset = 1'b0;
    step();
    drive(1'b1, 32'h0A0B0C0D, 1'b0, 1'b0, '0, 1'b0);
    chk("post_reset_pndng_before", 32'(pndng), 32'd0);
    step();
    idle();
    chk("post_reset_pndng_after", 32'(pndng), 32'd1);
    chk("post_reset_head", D_pop, 32'h0A0B0C0D);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(2))
        0:       dst = MY_ID;
        1:       dst = 8'hFF;
        default: dst = 8'($urandom);
      endcase
      drive(1'($urandom), $urandom, ($urandom_range(2) == 0), 1'($urandom),
            {dst, 24'($urandom)}, ($urandom_range(2) == 0));
      step();
    end
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
